// File: rtl/windowed_reg_file.sv
// Windowed register file: a ring of NUM_WIN resident register windows with
// push/pop switching, two combinational read ports and one write port.
// Ring overflow spills the oldest window to data memory; underflow fills a
// window back. busy is high while a spill or fill is moving words.
module windowed_reg_file #(
    parameter int                DATA_W      = 16,
    parameter int                REGS        = 4,
    parameter int                NUM_WIN     = 4,
    parameter int                SPILL_DEPTH = 8,
    parameter int                MEM_AW      = 10,
    parameter logic [MEM_AW-1:0] SPILL_BASE  = 'h100,
    localparam int               REG_AW      = $clog2(REGS),
    localparam int               WIN_AW      = $clog2(NUM_WIN),
    localparam int               DEP_W       = $clog2(SPILL_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rd_i_addr,
    input  logic [REG_AW-1:0] rd_j_addr,
    output logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_j,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              push,
    input  logic              pop,
    output logic              busy,
    output logic [WIN_AW-1:0] cwp,
    output logic [DEP_W-1:0]  depth,
    output logic              fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    typedef enum logic [1:0] {IDLE, SPILL, FILL} state_t;

    localparam logic [WIN_AW:0]  OCC_FULL = (WIN_AW + 1)'(NUM_WIN);
    localparam logic [WIN_AW:0]  OCC_ONE  = (WIN_AW + 1)'(1);
    localparam logic [DEP_W-1:0] DEP_MAX  = DEP_W'(SPILL_DEPTH);
    localparam logic [REG_AW:0]  WORD_END = (REG_AW + 1)'(REGS);

    state_t            state_q, state_d;
    logic [WIN_AW-1:0] cwp_q, cwp_d;
    logic [WIN_AW:0]   occ_q, occ_d;
    logic [DEP_W-1:0]  depth_q, depth_d;
    logic [REG_AW:0]   word_q, word_d;
    logic              fault_q, fault_d;

    logic [DATA_W-1:0] rf_q [NUM_WIN][REGS];

    logic              wr_go;
    logic              fill_go;
    logic              clr_en;
    logic              last_phase;
    logic [WIN_AW-1:0] vic;
    logic [WIN_AW-1:0] tgt;
    logic [REG_AW-1:0] word_idx;
    logic [DEP_W-1:0]  slot_idx;

    // The spill victim is the slot ahead of cwp; the fill target is the slot behind.
    assign vic        = cwp_q + 1'b1;
    assign tgt        = cwp_q - 1'b1;
    assign word_idx   = word_q[REG_AW-1:0];
    // After the last word is acknowledged one extra busy cycle commits the switch.
    assign last_phase = (word_q == WORD_END);

    assign data_i = rf_q[cwp_q][rd_i_addr];
    assign data_j = rf_q[cwp_q][rd_j_addr];

    assign busy  = (state_q != IDLE);
    assign cwp   = cwp_q;
    assign depth = depth_q;
    assign fault = fault_q;

    // Memory request fields depend only on state, word counter and depth, so
    // they stay stable for as long as the memory withholds mem_ack.
    assign slot_idx  = (state_q == FILL) ? depth_q - 1'b1 : depth_q;
    assign mem_req   = busy && !last_phase;
    assign mem_we    = mem_req && (state_q == SPILL);
    assign mem_addr  = mem_req ? SPILL_BASE + MEM_AW'(slot_idx) * MEM_AW'(REGS) + MEM_AW'(word_idx)
                               : '0;
    assign mem_wdata = mem_we ? rf_q[vic][word_idx] : '0;

    // Control next-state: window switching, spill/fill sequencing and fault detection.
    always_comb begin
        state_d = state_q;
        cwp_d   = cwp_q;
        occ_d   = occ_q;
        depth_d = depth_q;
        word_d  = word_q;
        fault_d = fault_q;
        wr_go   = 1'b0;
        fill_go = 1'b0;
        clr_en  = 1'b0;
        case (state_q)
            IDLE: begin
                wr_go = wr_en;
                if (push && !pop) begin
                    if (occ_q != OCC_FULL) begin
                        cwp_d  = cwp_q + 1'b1;
                        occ_d  = occ_q + 1'b1;
                        clr_en = 1'b1;
                    end else if (depth_q != DEP_MAX) begin
                        state_d = SPILL;
                        word_d  = '0;
                    end else begin
                        fault_d = 1'b1;
                    end
                end else if (pop && !push) begin
                    if (occ_q != OCC_ONE) begin
                        cwp_d = cwp_q - 1'b1;
                        occ_d = occ_q - 1'b1;
                    end else if (depth_q != '0) begin
                        state_d = FILL;
                        word_d  = '0;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            SPILL, FILL: begin
                if (last_phase) begin
                    state_d = IDLE;
                    word_d  = '0;
                    if (state_q == SPILL) begin
                        cwp_d   = vic;
                        depth_d = depth_q + 1'b1;
                        clr_en  = 1'b1;
                    end else begin
                        cwp_d   = tgt;
                        depth_d = depth_q - 1'b1;
                    end
                end else if (mem_ack) begin
                    word_d  = word_q + 1'b1;
                    fill_go = (state_q == FILL);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; reset abandons any spill or fill in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cwp_q   <= '0;
            occ_q   <= OCC_ONE;
            depth_q <= '0;
            word_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cwp_q   <= cwp_d;
            occ_q   <= occ_d;
            depth_q <= depth_d;
            word_q  <= word_d;
            fault_q <= fault_d;
        end
    end

    // Register storage: user writes, fill loads and clearing of a newly opened window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int w = 0; w < NUM_WIN; w++) begin
                for (int r = 0; r < REGS; r++) begin
                    rf_q[w][r] <= '0;
                end
            end
        end else begin
            if (wr_go) begin
                rf_q[cwp_q][wr_addr] <= wr_data;
            end
            if (fill_go) begin
                rf_q[tgt][word_idx] <= mem_rdata;
            end
            if (clr_en) begin
                for (int r = 0; r < REGS; r++) begin
                    rf_q[vic][r] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_windowed_reg_file.sv
// Scoreboard bench for windowed_reg_file: stimulus queues expected memory
// transactions, busy run lengths and status snapshots; a monitor compares
// them against the DUT as it presents them.
module tb_windowed_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rd_i_addr, rd_j_addr, wr_addr;
    logic [15:0] data_i, data_j, wr_data;
    logic        wr_en, push, pop;
    logic        busy;
    logic [1:0]  cwp;
    logic [3:0]  depth;
    logic        fault;
    logic        mem_req, mem_we;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_ack = 1'b0;

    always #5 clk = ~clk;

    windowed_reg_file dut (
        .clk       (clk),
        .rst       (rst),
        .rd_i_addr (rd_i_addr),
        .rd_j_addr (rd_j_addr),
        .data_i    (data_i),
        .data_j    (data_j),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .push      (push),
        .pop       (pop),
        .busy      (busy),
        .cwp       (cwp),
        .depth     (depth),
        .fault     (fault),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    typedef struct packed {
        logic        we;
        logic [9:0]  addr;
        logic [15:0] wdata;
    } txn_t;

    typedef struct packed {
        int          id;
        logic [1:0]  cwp;
        logic [3:0]  depth;
        logic        fault;
        logic        busy;
        logic        req;
        logic [15:0] di;
        logic [15:0] dj;
    } stat_t;

    txn_t  exp_q[$];
    stat_t stat_q[$];
    int    blen_q[$];

    int checks   = 0;
    int errors   = 0;
    int ack_seen = 0;
    int run      = 0;
    bit done     = 1'b0;
    int ack_wait = 0;
    int wcnt     = 0;
    logic [15:0] mem_model [0:1023];

    // Memory model: acknowledges each word after ack_wait idle cycles.
    always @(negedge clk) begin
        if (rst === 1'b1 && mem_req === 1'b1) begin
            if (wcnt == ack_wait) begin
                mem_ack = 1'b1;
                wcnt    = 0;
                if (mem_we) mem_model[mem_addr] = mem_wdata;
                else        mem_rdata = mem_model[mem_addr];
            end else begin
                mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end
    end

    // Monitor: compares status snapshots, memory transactions and busy run lengths.
    always @(negedge clk) begin
        stat_t s;
        txn_t  t;
        int    e;
        #1;
        if (stat_q.size() > 0) begin
            s = stat_q.pop_front();
            checks++;
            if (cwp !== s.cwp || depth !== s.depth || fault !== s.fault || busy !== s.busy ||
                mem_req !== s.req || data_i !== s.di || data_j !== s.dj) begin
                errors++;
                $display("FAIL stat%0d got cwp=%0d depth=%0d fault=%b busy=%b req=%b di=%h dj=%h want cwp=%0d depth=%0d fault=%b busy=%b req=%b di=%h dj=%h",
                         s.id, cwp, depth, fault, busy, mem_req, data_i, data_j,
                         s.cwp, s.depth, s.fault, s.busy, s.req, s.di, s.dj);
            end
        end
        if (rst === 1'b1 && mem_req === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mem_txn got unexpected request we=%b addr=%h want none", mem_we, mem_addr);
            end else begin
                t = exp_q[0];
                if (mem_we !== t.we || mem_addr !== t.addr || (t.we && mem_wdata !== t.wdata)) begin
                    errors++;
                    $display("FAIL mem_txn got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                             mem_we, mem_addr, mem_wdata, t.we, t.addr, t.wdata);
                end
                if (mem_ack === 1'b1) begin
                    void'(exp_q.pop_front());
                    ack_seen++;
                end
            end
        end
        if (busy === 1'b1) begin
            run++;
        end else if (run > 0) begin
            checks++;
            if (blen_q.size() == 0) begin
                errors++;
                $display("FAIL busy_len got %0d want none", run);
            end else begin
                e = blen_q.pop_front();
                if (run != e) begin
                    errors++;
                    $display("FAIL busy_len got %0d want %0d", run, e);
                end
            end
            run = 0;
        end
        if (done) begin
            checks++;
            if (exp_q.size() != 0 || blen_q.size() != 0 || stat_q.size() != 0) begin
                errors++;
                $display("FAIL leftover got txn=%0d blen=%0d stat=%0d want 0 0 0",
                         exp_q.size(), blen_q.size(), stat_q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    int sid = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] i, input logic [1:0] j);
        rd_i_addr = i;
        rd_j_addr = j;
    endtask

    task automatic chk(input logic [1:0] c, input logic [3:0] d, input logic f, input logic b,
                       input logic r, input logic [15:0] di, input logic [15:0] dj);
        stat_t s;
        s = '{id: sid, cwp: c, depth: d, fault: f, busy: b, req: r, di: di, dj: dj};
        stat_q.push_back(s);
        sid++;
        step();
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_push();
        push = 1'b1;
        step();
        push = 1'b0;
    endtask

    task automatic do_pop();
        pop = 1'b1;
        step();
        pop = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0) begin
            step();
            n++;
            if (n > 500) begin
                $display("FAIL wait_idle got busy stuck want idle");
                $fatal(1);
            end
        end
    endtask

    task automatic exp_block(input logic we, input logic [9:0] base, input logic [15:0] w0,
                             input logic [15:0] w1, input logic [15:0] w2, input logic [15:0] w3);
        logic [15:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back('{we: we, addr: base + 10'(k), wdata: w[k]});
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        int base;
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        push = 1'b0; pop = 1'b0; rd_i_addr = '0; rd_j_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        rd(0, 3);
        chk(2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        rst = 1'b1;
        step();

        // Write then read back, fill window 0
        wr(2, 16'h1234);
        rd(2, 0);
        chk(2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0);
        wr(0, 16'hA000); wr(1, 16'hA001); wr(3, 16'hA003);
        rd(0, 3);
        chk(2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'hA000, 16'hA003);

        // Three zero-stall pushes; the second carries a write into the old window
        do_push();
        rd(0, 1);
        chk(2'd1, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        push = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'h1111;
        step();
        push = 1'b0; wr_en = 1'b0;
        chk(2'd2, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        do_push();
        chk(2'd3, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

        // Fourth push spills window 0 to 0x100..0x103
        exp_block(1'b1, 10'h100, 16'hA000, 16'hA001, 16'h1234, 16'hA003);
        blen_q.push_back(5);
        do_push();
        chk(2'd3, 4'd0, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0);
        wait_idle();
        rd(0, 1);
        chk(2'd0, 4'd1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        rd(2, 3);
        chk(2'd0, 4'd1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

        // Three pops back to window 1, then a fill
        do_pop();
        chk(2'd3, 4'd1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        do_pop();
        chk(2'd2, 4'd1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        do_pop();
        rd(0, 0);
        chk(2'd1, 4'd1, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h1111);
        exp_block(1'b0, 10'h100, 16'h0, 16'h0, 16'h0, 16'h0);
        blen_q.push_back(5);
        do_pop();
        wait_idle();
        rd(0, 1);
        chk(2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'hA000, 16'hA001);
        rd(2, 3);
        chk(2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'hA003);

        // Fifth pop underflows with nothing spilled
        do_pop();
        rd(0, 0);
        chk(2'd0, 4'd0, 1'b1, 1'b0, 1'b0, 16'hA000, 16'hA000);

        // Asynchronous reset clears fault and registers
        rst = 1'b0;
        #1;
        chk(2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        rst = 1'b1;
        step();

        // push+pop together is a no-op
        wr(0, 16'h5A00); wr(1, 16'h5A01); wr(2, 16'h5A02); wr(3, 16'h5A03);
        push = 1'b1; pop = 1'b1;
        step();
        push = 1'b0; pop = 1'b0;
        rd(0, 3);
        chk(2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h5A00, 16'h5A03);

        // Slow-memory spill with commands issued while busy
        do_push(); do_push(); do_push();
        ack_wait = 3;
        exp_block(1'b1, 10'h100, 16'h5A00, 16'h5A01, 16'h5A02, 16'h5A03);
        blen_q.push_back(17);
        do_push();
        push = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'hDEAD;
        step();
        push = 1'b0; wr_en = 1'b0; pop = 1'b1;
        step();
        pop = 1'b0;
        wait_idle();
        rd(0, 3);
        chk(2'd0, 4'd1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        do_pop();
        rd(0, 0);
        chk(2'd3, 4'd1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

        // Reset in the middle of a spill, after the second ack
        ack_wait = 0;
        do_reset();
        do_push(); do_push(); do_push();
        exp_block(1'b1, 10'h100, 16'h0, 16'h0, 16'h0, 16'h0);
        blen_q.push_back(2);
        base = ack_seen;
        do_push();
        for (int n = 0; ack_seen < base + 2; n++) begin
            if (n > 50) begin
                $display("FAIL mid_spill_ack got %0d acks want 2", ack_seen - base);
                $fatal(1);
            end
            step();
        end
        rst = 1'b0;
        #1;
        exp_q.delete();
        chk(2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        rst = 1'b1;
        step();
        chk(2'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);

        done = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL summary got no end of run want summary");
        $fatal(1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
